// File: rtl/pwm_pkg.sv
// pwm_pkg: register addresses, CTRL bit positions and the CTRL type
// shared by pwm_channel and pwm_multi_ch.
// Build option: PWM_CENTER_ALIGN_EN adds the CTRL center-align bit.
package pwm_pkg;

   localparam logic [1:0] ADDR_PERIOD = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_POL = 1;
   localparam int CTRL_CTR = 2;

   typedef struct packed {
`ifdef PWM_CENTER_ALIGN_EN
      logic ctr;
`endif
      logic pol;
      logic en;
   } pwm_ctrl_t;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel - shadow/active period+duty, counter,
// CTRL flops, registered output and period-start strobe.
// Ports: clk, rst (sync, active-high), we/waddr/wdata (decoded write),
//        pwm_out (registered level), period_stb (cnt restarted at 0).
// Build option: PWM_CENTER_ALIGN_EN enables up/down counting.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [1:0]       waddr,
   input  logic [CNT_W-1:0] wdata,
   output logic             pwm_out,
   output logic             period_stb
);

   pwm_ctrl_t        ctrl_q, ctrl_d;
   logic [CNT_W-1:0] per_sh_q, per_sh_d;
   logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
   logic [CNT_W-1:0] per_act_q, per_act_d;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stb_q, stb_d;
   logic             out_q, out_d;
   logic             wrap;
   logic             raw;
`ifdef PWM_CENTER_ALIGN_EN
   logic             dir_q, dir_d;
`endif

   // Register writes: period/duty go to shadow, CTRL applies directly.
   always_comb begin
      per_sh_d  = per_sh_q;
      duty_sh_d = duty_sh_q;
      ctrl_d    = ctrl_q;
      if (we) begin
         unique case (waddr)
            ADDR_PERIOD: per_sh_d = wdata;
            ADDR_DUTY:   duty_sh_d = wdata;
            ADDR_CTRL: begin
               ctrl_d.en  = wdata[CTRL_EN];
               ctrl_d.pol = wdata[CTRL_POL];
`ifdef PWM_CENTER_ALIGN_EN
               ctrl_d.ctr = wdata[CTRL_CTR];
`endif
            end
            default: ;
         endcase
      end
   end

   // Counter, shadow->active copy and strobe.
   // The copy reads shadow_q, so a write in the wrap cycle
   // waits for the following wrap.
   always_comb begin
      per_act_d  = per_act_q;
      duty_act_d = duty_act_q;
      cnt_d      = cnt_q;
      stb_d      = 1'b0;
      wrap       = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d      = dir_q;
`endif
      if (!ctrl_q.en) begin
         per_act_d  = per_sh_q;
         duty_act_d = duty_sh_q;
         cnt_d      = '0;
         stb_d      = ctrl_d.en;
`ifdef PWM_CENTER_ALIGN_EN
         // Park at the valley so enable starts a fresh up-slope.
         dir_d      = 1'b1;
`endif
      end else begin
`ifdef PWM_CENTER_ALIGN_EN
         if (ctrl_q.ctr) begin
            if (per_act_q == '0) begin
               wrap  = 1'b1;
               cnt_d = '0;
               dir_d = 1'b1;
            end else if (dir_q) begin
               if (cnt_q == '0) begin
                  wrap  = 1'b1;
                  cnt_d = CNT_W'(1);
                  dir_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               if (cnt_q >= per_act_q) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  dir_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            stb_d = dir_d && (cnt_d == '0);
         end else begin
`endif
            wrap  = (cnt_q == per_act_q);
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            stb_d = wrap;
`ifdef PWM_CENTER_ALIGN_EN
         end
`endif
         if (wrap) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
         end
         if (!ctrl_d.en) begin
            cnt_d = '0;
            stb_d = 1'b0;
         end
      end
   end

   always_comb begin
      raw   = (cnt_q < duty_act_q);
      out_d = ctrl_q.en ? (raw ^ ctrl_q.pol) : ctrl_q.pol;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q     <= '0;
         per_sh_q   <= '0;
         duty_sh_q  <= '0;
         per_act_q  <= '0;
         duty_act_q <= '0;
         cnt_q      <= '0;
         stb_q      <= 1'b0;
         out_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q      <= 1'b0;
`endif
      end else begin
         ctrl_q     <= ctrl_d;
         per_sh_q   <= per_sh_d;
         duty_sh_q  <= duty_sh_d;
         per_act_q  <= per_act_d;
         duty_act_q <= duty_act_d;
         cnt_q      <= cnt_d;
         stb_q      <= stb_d;
         out_q      <= out_d;
`ifdef PWM_CENTER_ALIGN_EN
         dir_q      <= dir_d;
`endif
      end
   end

   assign pwm_out    = out_q;
   assign period_stb = stb_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: NUM_CH-channel PWM generator with shadowed registers.
// Ports: clk, rst (sync, active-high); wr_en/wr_ch/wr_addr/wr_data
//        register bus; wr_ack/wr_err write response (1-cycle latency);
//        pwm_out[NUM_CH], period_stb[NUM_CH].
// Build option: PWM_CENTER_ALIGN_EN enables center-aligned mode.
module pwm_multi_ch
   import pwm_pkg::*;
#(
   parameter  int NUM_CH = 8,
   parameter  int CNT_W  = 16,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [1:0]        wr_addr,
   input  logic [CNT_W-1:0]  wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] period_stb
);

   logic              bad;
   logic [NUM_CH-1:0] ch_we;
   logic              ack_q, ack_d;
   logic              err_q, err_d;

   // Bad writes are acknowledged with an error and reach no channel.
   always_comb begin
      bad   = (32'(wr_ch) >= 32'(NUM_CH)) || (wr_addr == ADDR_RSVD);
      ack_d = wr_en;
      err_d = wr_en && bad;
      ch_we = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_we[c] = wr_en && !bad && (32'(wr_ch) == 32'(c));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
      end
   end

   assign wr_ack = ack_q;
   assign wr_err = err_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pwm_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .we        (ch_we[i]),
         .waddr     (wr_addr),
         .wdata     (wr_data),
         .pwm_out   (pwm_out[i]),
         .period_stb(period_stb[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: self-checking bench for pwm_multi_ch (NUM_CH=6).
// Table of PWM configurations plus hand sequences for corner cases.
module tb_pwm_multi_ch;
   import pwm_pkg::*;

   localparam int NUM_CH = 6;
   localparam int CNT_W  = 16;
   localparam int CH_W   = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [1:0]        wr_addr;
   logic [CNT_W-1:0]  wr_data;
   logic              wr_ack;
   logic              wr_err;
   logic [NUM_CH-1:0] pwm_out;
   logic [NUM_CH-1:0] period_stb;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic pwm;
      logic stb;
   } exp_t;

   typedef struct {
      int per;
      int duty;
      int ctrl;
      int hi;
   } vec_t;

   exp_t sbq[$];
   logic ack_sbq[$];
   vec_t vecs[8];
   exp_t e;
   logic ae;
   bit   ok;
   int   dty;
   int   pos;
   logic act;

   pwm_multi_ch #(
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_ch     (wr_ch),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .wr_err    (wr_err),
      .pwm_out   (pwm_out),
      .period_stb(period_stb)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic wr(input int ch, input int addr, input int data,
                     input logic exp_err);
      logic x;
      wr_en   = 1'b1;
      wr_ch   = CH_W'(ch);
      wr_addr = 2'(addr);
      wr_data = CNT_W'(data);
      ack_sbq.push_back(exp_err);
      @(negedge clk);
      wr_en = 1'b0;
      x = ack_sbq.pop_front();
      check("wr_ack", 32'(wr_ack), 32'd1);
      check("wr_err", 32'(wr_err), 32'(x));
   endtask

   task automatic cfg(input int ch, input int per, input int duty,
                      input int ctrl);
      wr(ch, ADDR_CTRL, 0, 1'b0);
      wr(ch, ADDR_PERIOD, per, 1'b0);
      wr(ch, ADDR_DUTY, duty, 1'b0);
      @(negedge clk);
      wr(ch, ADDR_CTRL, ctrl, 1'b0);
   endtask

   task automatic wait_stb(input int ch, output bit found);
      found = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (period_stb[ch]) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL wait_stb ch%0d: got none expected strobe", ch);
      end
   endtask

   initial begin
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_ch   = '0;
      wr_addr = '0;
      wr_data = '0;

      // {period, duty, ctrl, active cycles per period}
      vecs[0] = '{9, 3, 1, 3};
      vecs[1] = '{9, 0, 1, 0};
      vecs[2] = '{9, 10, 1, 10};
      vecs[3] = '{9, 3, 3, 3};
      vecs[4] = '{0, 1, 1, 1};
      vecs[5] = '{4, 4, 1, 4};
      vecs[6] = '{5, 2, 3, 2};
      vecs[7] = '{3, 0, 3, 0};

      repeat (3) @(negedge clk);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_stb", 32'(period_stb), 32'd0);
      check("rst_ack", 32'(wr_ack), 32'd0);
      check("rst_err", 32'(wr_err), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Disabled channel drives its polarity level.
      wr(3, ADDR_CTRL, 2, 1'b0);
      @(negedge clk);
      check("dis_pol", 32'(pwm_out[3]), 32'd1);
      wr(3, ADDR_CTRL, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("dis_pol_off", 32'(pwm_out), 32'd0);

      foreach (vecs[v]) begin
         cfg(0, vecs[v].per, vecs[v].duty, vecs[v].ctrl);
         wait_stb(0, ok);
         if (ok) begin
            act = ~vecs[v].ctrl[1];
            for (int j = 1; j <= 2 * (vecs[v].per + 1); j++) begin
               pos = (j - 1) % (vecs[v].per + 1);
               sbq.push_back(exp_t'{
                  pwm: (pos < vecs[v].hi) ? act : ~act,
                  stb: (j % (vecs[v].per + 1)) == 0});
               @(negedge clk);
               e = sbq.pop_front();
               check($sformatf("v%0d_pwm", v), 32'(pwm_out[0]), 32'(e.pwm));
               check($sformatf("v%0d_stb", v), 32'(period_stb[0]),
                     32'(e.stb));
               check($sformatf("v%0d_other", v),
                     32'({pwm_out[NUM_CH-1:1], period_stb[NUM_CH-1:1]}),
                     32'd0);
            end
         end
      end

      // Mid-period duty write, then a write in the wrap cycle.
      cfg(0, 9, 3, 1);
      wait_stb(0, ok);
      if (ok) begin
         for (int j = 1; j <= 40; j++) begin
            wr_en = 1'b0;
            if (j == 4 || j == 20) begin
               wr_en   = 1'b1;
               wr_ch   = '0;
               wr_addr = ADDR_DUTY;
               wr_data = (j == 4) ? CNT_W'(7) : CNT_W'(5);
               ack_sbq.push_back(1'b0);
            end
            dty = (j <= 10) ? 3 : (j <= 30) ? 7 : 5;
            sbq.push_back(exp_t'{pwm: ((j - 1) % 10) < dty,
                                 stb: (j % 10) == 0});
            @(negedge clk);
            wr_en = 1'b0;
            e = sbq.pop_front();
            check("mid_pwm", 32'(pwm_out[0]), 32'(e.pwm));
            check("mid_stb", 32'(period_stb[0]), 32'(e.stb));
            if (j == 4 || j == 20) begin
               ae = ack_sbq.pop_front();
               check("mid_ack", 32'(wr_ack), 32'd1);
               check("mid_err", 32'(wr_err), 32'(ae));
            end
         end
      end

      // Rejected writes: ack+err, no channel state changes.
      wr(6, ADDR_CTRL, 1, 1'b1);
      wr(7, ADDR_DUTY, 0, 1'b1);
      wr(1, 3, 1, 1'b1);
      wr(0, 3, 0, 1'b1);
      wait_stb(0, ok);
      if (ok) begin
         for (int j = 1; j <= 10; j++) begin
            sbq.push_back(exp_t'{pwm: (j - 1) < 5, stb: j == 10});
            @(negedge clk);
            e = sbq.pop_front();
            check("err_pwm", 32'(pwm_out[0]), 32'(e.pwm));
            check("err_stb", 32'(period_stb[0]), 32'(e.stb));
            check("err_other",
                  32'({pwm_out[NUM_CH-1:1], period_stb[NUM_CH-1:1]}),
                  32'd0);
         end
      end

      // Reset with three channels running and a write in flight.
      cfg(2, 5, 2, 1);
      cfg(4, 7, 3, 3);
      wait_stb(2, ok);
      repeat (3) @(negedge clk);
      rst     = 1'b1;
      wr_en   = 1'b1;
      wr_ch   = '0;
      wr_addr = ADDR_DUTY;
      wr_data = CNT_W'(1);
      @(negedge clk);
      rst   = 1'b0;
      wr_en = 1'b0;
      check("mrst_pwm", 32'(pwm_out), 32'd0);
      check("mrst_stb", 32'(period_stb), 32'd0);
      check("mrst_ack", 32'(wr_ack), 32'd0);
      check("mrst_err", 32'(wr_err), 32'd0);
      @(negedge clk);

      // Only enable ch0: cleared period/duty give stb every cycle, low out.
      wr(0, ADDR_CTRL, 1, 1'b0);
      for (int j = 0; j < 4; j++) begin
         check("post_stb", 32'(period_stb), 32'd1);
         @(negedge clk);
         check("post_pwm", 32'(pwm_out), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
